// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared encodings for the RV32I(M) decode stage: opcode/funct constants,
// control-select encodings, the 5-bit ALU function enum and the packed
// control bundle carried from decode to execute.
// -----------------------------------------------------------------------------
package riscv_pkg;

   // Major opcodes
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;

   // ALU funct3
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // Branch funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // funct7
   localparam logic [6:0] F7_BASE   = 7'h00;
   localparam logic [6:0] F7_ALT    = 7'h20;
   localparam logic [6:0] F7_MULDIV = 7'h01;

   // Memory access mask: the load/store funct3 is passed through unchanged
   localparam logic [2:0] MASK_B  = 3'b000;
   localparam logic [2:0] MASK_H  = 3'b001;
   localparam logic [2:0] MASK_W  = 3'b010;
   localparam logic [2:0] MASK_BU = 3'b100;
   localparam logic [2:0] MASK_HU = 3'b101;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2, BR_LT = 3'd3,
      BR_GE   = 3'd4, BR_LTU = 3'd5, BR_GEU = 3'd6
   } br_func_e;

   typedef enum logic [1:0] {
      PC_NEXTPC = 2'd0, PC_JAL = 2'd1, PC_JALR = 2'd2, PC_BR = 2'd3
   } pc_sel_e;

   typedef enum logic { OP1_RS1 = 1'b0, OP1_PC  = 1'b1 } op1_sel_e;
   typedef enum logic { OP2_RS2 = 1'b0, OP2_IMM = 1'b1 } op2_sel_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2
   } wb_sel_e;

   // M ops are contiguous in funct3 order so they can be offset from ALU_MUL
   typedef enum logic [4:0] {
      ALU_NONE   = 5'd0,  ALU_ADD   = 5'd1,  ALU_SUB  = 5'd2,  ALU_SLL   = 5'd3,
      ALU_SLT    = 5'd4,  ALU_SLTU  = 5'd5,  ALU_XOR  = 5'd6,  ALU_SRL   = 5'd7,
      ALU_SRA    = 5'd8,  ALU_OR    = 5'd9,  ALU_AND  = 5'd10, ALU_COPY_B = 5'd11,
      ALU_MUL    = 5'd12, ALU_MULH  = 5'd13, ALU_MULHSU = 5'd14, ALU_MULHU = 5'd15,
      ALU_DIV    = 5'd16, ALU_DIVU  = 5'd17, ALU_REM  = 5'd18, ALU_REMU  = 5'd19
   } alu_func_e;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      br_func_e    br_func;
      pc_sel_e     pc_sel;
      op1_sel_e    op1_sel;
      op2_sel_e    op2_sel;
      wb_sel_e     wb_sel;
      alu_func_e   alu_func;
      logic        we_rf;
      logic        dmem_re;
      logic        dmem_we;
      logic [2:0]  dmem_size;
      logic        illegal;
   } dec_ctrl_t;

   localparam dec_ctrl_t DEC_NOP = '{
      rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0,
      br_func: BR_NONE, pc_sel: PC_NEXTPC, op1_sel: OP1_RS1, op2_sel: OP2_RS2,
      wb_sel: WB_ALU, alu_func: ALU_NONE, we_rf: 1'b0, dmem_re: 1'b0,
      dmem_we: 1'b0, dmem_size: MASK_B, illegal: 1'b0
   };

   // Base integer ALU op for a funct3; alt selects SUB/SRA.
   function automatic alu_func_e alu_base(input logic [2:0] f3, input logic alt);
      alu_func_e r;
      case (f3)
         F3_ADD:  r = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  r = ALU_SLL;
         F3_SLT:  r = ALU_SLT;
         F3_SLTU: r = ALU_SLTU;
         F3_XOR:  r = ALU_XOR;
         F3_SR:   r = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/riscv_decode_comb.sv
// -----------------------------------------------------------------------------
// riscv_decode_comb
// Purely combinational RV32I(M) decoder.
//   inst_in  : 32-bit instruction word
//   ctrl_out : decoded control bundle, including the illegal flag
// Illegal encodings collapse to the NOP bundle (register fields kept) with
// illegal set. Writes to x0 are suppressed here.
// -----------------------------------------------------------------------------
module riscv_decode_comb
   import riscv_pkg::*;
#(
   parameter bit ENABLE_M = 1'b0
) (
   input  logic [31:0] inst_in,
   output dec_ctrl_t   ctrl_out
);

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = inst_in[6:0];
   assign f3     = inst_in[14:12];
   assign f7     = inst_in[31:25];

   assign imm_i = {{20{inst_in[31]}}, inst_in[31:20]};
   assign imm_s = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
   assign imm_b = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25],
                   inst_in[11:8], 1'b0};
   assign imm_u = {inst_in[31:12], 12'd0};
   assign imm_j = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20],
                   inst_in[30:21], 1'b0};

   dec_ctrl_t c;
   logic      legal;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves it unassigned and infers a latch.
      c       = DEC_NOP;
      c.rs1   = inst_in[19:15];
      c.rs2   = inst_in[24:20];
      c.rd    = inst_in[11:7];
      legal   = 1'b1;

      case (opcode)
         OPC_LUI: begin
            c.imm      = imm_u;
            c.op2_sel  = OP2_IMM;
            c.alu_func = ALU_COPY_B;
            c.we_rf    = 1'b1;
         end
         OPC_AUIPC: begin
            c.imm      = imm_u;
            c.op1_sel  = OP1_PC;
            c.op2_sel  = OP2_IMM;
            c.alu_func = ALU_ADD;
            c.we_rf    = 1'b1;
         end
         OPC_JAL: begin
            c.imm      = imm_j;
            c.pc_sel   = PC_JAL;
            c.op1_sel  = OP1_PC;
            c.op2_sel  = OP2_IMM;
            c.alu_func = ALU_ADD;
            c.wb_sel   = WB_PC4;
            c.we_rf    = 1'b1;
         end
         OPC_JALR: begin
            legal      = (f3 == 3'b000);
            c.imm      = imm_i;
            c.pc_sel   = PC_JALR;
            c.op2_sel  = OP2_IMM;
            c.alu_func = ALU_ADD;
            c.wb_sel   = WB_PC4;
            c.we_rf    = 1'b1;
         end
         OPC_BR: begin
            c.imm      = imm_b;
            c.pc_sel   = PC_BR;
            c.op1_sel  = OP1_PC;
            c.op2_sel  = OP2_IMM;
            c.alu_func = ALU_ADD;
            case (f3)
               F3_BEQ:  c.br_func = BR_EQ;
               F3_BNE:  c.br_func = BR_NE;
               F3_BLT:  c.br_func = BR_LT;
               F3_BGE:  c.br_func = BR_GE;
               F3_BLTU: c.br_func = BR_LTU;
               F3_BGEU: c.br_func = BR_GEU;
               default: legal     = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            legal       = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            c.imm       = imm_i;
            c.op2_sel   = OP2_IMM;
            c.alu_func  = ALU_ADD;
            c.wb_sel    = WB_MEM;
            c.we_rf     = 1'b1;
            c.dmem_re   = 1'b1;
            c.dmem_size = f3;
         end
         OPC_STORE: begin
            legal       = (f3 < 3'b011);
            c.imm       = imm_s;
            c.op2_sel   = OP2_IMM;
            c.alu_func  = ALU_ADD;
            c.dmem_we   = 1'b1;
            c.dmem_size = f3;
         end
         OPC_OPIMM: begin
            // imm[11:5] doubles as funct7 only for shifts; ADDI must never
            // turn into SUB because of its immediate.
            c.imm      = imm_i;
            c.op2_sel  = OP2_IMM;
            c.we_rf    = 1'b1;
            c.alu_func = alu_base(f3, (f3 == F3_SR) && (f7 == F7_ALT));
            if (f3 == F3_SLL)
               legal = (f7 == F7_BASE);
            else if (f3 == F3_SR)
               legal = (f7 == F7_BASE) || (f7 == F7_ALT);
         end
         OPC_OP: begin
            c.we_rf = 1'b1;
            if (f7 == F7_BASE)
               c.alu_func = alu_base(f3, 1'b0);
            else if ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)))
               c.alu_func = alu_base(f3, 1'b1);
            else if ((f7 == F7_MULDIV) && ENABLE_M)
               c.alu_func = alu_func_e'(5'(ALU_MUL) + 5'(f3));
            else
               legal = 1'b0;
         end
         default: legal = 1'b0;
      endcase

      if (!legal) begin
         c         = DEC_NOP;
         c.rs1     = inst_in[19:15];
         c.rs2     = inst_in[24:20];
         c.rd      = inst_in[11:7];
         c.illegal = 1'b1;
      end

      if (c.rd == 5'd0)
         c.we_rf = 1'b0;
   end

   assign ctrl_out = c;

endmodule

// File: rtl/riscv_decode_stage.sv
// -----------------------------------------------------------------------------
// riscv_decode_stage
// Registered RV32I(M) decode stage with valid/ready handshake and a one-entry
// skid buffer, so inst_ready_out is a flop rather than a function of
// dec_ready_in.
//   clk_in, rst_n_in      : clock, async active-low reset
//   flush_in              : synchronous flush of all held instructions
//   inst_valid_in/_ready_out, inst_in, pc_in : fetch side
//   dec_valid_out/dec_ready_in, pc_out and the control bundle : execute side
//   illegal_out           : instruction is not a legal RV32I(M) encoding
//   decode_count_out      : number of output handshakes (wraps)
// -----------------------------------------------------------------------------
module riscv_decode_stage
   import riscv_pkg::*;
#(
   parameter bit ENABLE_M = 1'b0,
   parameter int PC_WIDTH = 32
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                flush_in,
   input  logic                inst_valid_in,
   output logic                inst_ready_out,
   input  logic [31:0]         inst_in,
   input  logic [PC_WIDTH-1:0] pc_in,
   output logic                dec_valid_out,
   input  logic                dec_ready_in,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic [4:0]          rs1_out,
   output logic [4:0]          rs2_out,
   output logic [4:0]          rd_out,
   output logic [31:0]         imm_out,
   output logic [2:0]          br_func_out,
   output logic [1:0]          pc_sel_out,
   output logic                op1_sel_out,
   output logic                op2_sel_out,
   output logic [1:0]          writeback_sel_out,
   output logic [4:0]          alu_func_out,
   output logic                write_enable_rf_out,
   output logic                dmem_read_enable_out,
   output logic                dmem_write_enable_out,
   output logic [2:0]          dmem_size_out,
   output logic                illegal_out,
   output logic [31:0]         decode_count_out
);

   dec_ctrl_t           dec_c;
   dec_ctrl_t           or_ctrl, sk_ctrl;
   logic [PC_WIDTH-1:0] or_pc, sk_pc;
   logic                or_valid, sk_valid, ready_q;
   logic [31:0]         count_q;

   logic in_fire, out_fire, or_free;

   riscv_decode_comb #(.ENABLE_M(ENABLE_M)) u_decode (
      .inst_in  (inst_in),
      .ctrl_out (dec_c)
   );

   assign in_fire  = inst_valid_in & ready_q;
   assign out_fire = or_valid & dec_ready_in;
   // OR can take a new entry this edge if it is empty or being drained.
   assign or_free  = ~or_valid | out_fire;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         // NOTE: the datapath registers are reset as well so the bundle
         // reads as a NOP straight out of reset, not just the valid bits.
         or_valid <= 1'b0;
         sk_valid <= 1'b0;
         ready_q  <= 1'b1;
         or_ctrl  <= DEC_NOP;
         sk_ctrl  <= DEC_NOP;
         or_pc    <= '0;
         sk_pc    <= '0;
      end else if (flush_in) begin
         // NOTE: state is updated with non-blocking assignments so every
         // branch sees the pre-edge values of or_valid/sk_valid.
         or_valid <= 1'b0;
         sk_valid <= 1'b0;
         ready_q  <= 1'b1;
      end else if (or_free) begin
         if (sk_valid) begin
            // ready_q was low, so no input can be accepted this cycle.
            or_ctrl  <= sk_ctrl;
            or_pc    <= sk_pc;
            or_valid <= 1'b1;
            sk_valid <= 1'b0;
            ready_q  <= 1'b1;
         end else if (in_fire) begin
            or_ctrl  <= dec_c;
            or_pc    <= pc_in;
            or_valid <= 1'b1;
         end else begin
            or_valid <= 1'b0;
         end
      end else if (in_fire) begin
         // OR is stalled: absorb the one instruction already in flight.
         sk_ctrl  <= dec_c;
         sk_pc    <= pc_in;
         sk_valid <= 1'b1;
         ready_q  <= 1'b0;
      end
   end

   // Output handshakes are counted even in a flush cycle.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         count_q <= 32'd0;
      else if (out_fire)
         count_q <= count_q + 32'd1;
   end

   assign inst_ready_out        = ready_q;
   assign dec_valid_out         = or_valid;
   assign pc_out                = or_pc;
   assign rs1_out               = or_ctrl.rs1;
   assign rs2_out               = or_ctrl.rs2;
   assign rd_out                = or_ctrl.rd;
   assign imm_out               = or_ctrl.imm;
   assign br_func_out           = or_ctrl.br_func;
   assign pc_sel_out            = or_ctrl.pc_sel;
   assign op1_sel_out           = or_ctrl.op1_sel;
   assign op2_sel_out           = or_ctrl.op2_sel;
   assign writeback_sel_out     = or_ctrl.wb_sel;
   assign alu_func_out          = or_ctrl.alu_func;
   assign write_enable_rf_out   = or_ctrl.we_rf;
   assign dmem_read_enable_out  = or_ctrl.dmem_re;
   assign dmem_write_enable_out = or_ctrl.dmem_we;
   assign dmem_size_out         = or_ctrl.dmem_size;
   assign illegal_out           = or_ctrl.illegal;
   assign decode_count_out      = count_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_riscv_decode_stage
// Drives two instances (ENABLE_M = 0 and 1) with the same stimulus and checks
// both against a transaction-level model: a queue of accepted instructions
// plus an instruction-set decode function.
// -----------------------------------------------------------------------------
module tb_riscv_decode_stage;
   import riscv_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_n_in, flush_in, inst_valid_in, dec_ready_in;
   logic [31:0] inst_in, pc_in;

   logic [1:0]       dec_valid, inst_ready, op1, op2, we, re, wr, ill;
   logic [1:0][31:0] pc, imm, count;
   logic [1:0][4:0]  rs1, rs2, rd, alu;
   logic [1:0][2:0]  br, size;
   logic [1:0][1:0]  pcs, wb;

   always #5 clk_in = ~clk_in;

   riscv_decode_stage #(.ENABLE_M(1'b0), .PC_WIDTH(32)) dut0 (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in),
      .inst_valid_in(inst_valid_in), .inst_ready_out(inst_ready[0]),
      .inst_in(inst_in), .pc_in(pc_in), .dec_valid_out(dec_valid[0]),
      .dec_ready_in(dec_ready_in), .pc_out(pc[0]), .rs1_out(rs1[0]),
      .rs2_out(rs2[0]), .rd_out(rd[0]), .imm_out(imm[0]), .br_func_out(br[0]),
      .pc_sel_out(pcs[0]), .op1_sel_out(op1[0]), .op2_sel_out(op2[0]),
      .writeback_sel_out(wb[0]), .alu_func_out(alu[0]),
      .write_enable_rf_out(we[0]), .dmem_read_enable_out(re[0]),
      .dmem_write_enable_out(wr[0]), .dmem_size_out(size[0]),
      .illegal_out(ill[0]), .decode_count_out(count[0])
   );

   riscv_decode_stage #(.ENABLE_M(1'b1), .PC_WIDTH(32)) dut1 (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in),
      .inst_valid_in(inst_valid_in), .inst_ready_out(inst_ready[1]),
      .inst_in(inst_in), .pc_in(pc_in), .dec_valid_out(dec_valid[1]),
      .dec_ready_in(dec_ready_in), .pc_out(pc[1]), .rs1_out(rs1[1]),
      .rs2_out(rs2[1]), .rd_out(rd[1]), .imm_out(imm[1]), .br_func_out(br[1]),
      .pc_sel_out(pcs[1]), .op1_sel_out(op1[1]), .op2_sel_out(op2[1]),
      .writeback_sel_out(wb[1]), .alu_func_out(alu[1]),
      .write_enable_rf_out(we[1]), .dmem_read_enable_out(re[1]),
      .dmem_write_enable_out(wr[1]), .dmem_size_out(size[1]),
      .illegal_out(ill[1]), .decode_count_out(count[1])
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } item_t;

   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      int          br, pc_sel, op1, op2, wb, alu, size;
      bit          we, re, wr, ill;
   } exp_t;

   item_t       q[$];
   logic [31:0] exp_count;

   function automatic exp_t ref_decode(input logic [31:0] w, input bit m);
      exp_t      e, n;
      int        op, f3, f7, v;
      bit        legal;
      alu_func_e alu_tab[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      int        br_tab[8]  = '{BR_EQ, BR_NE, -1, -1, BR_LT, BR_GE, BR_LTU, BR_GEU};
      int        imm_i, imm_s, imm_b, imm_j;
      op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
      // Immediates from two's-complement arithmetic on the raw field values.
      imm_i = int'(w[31:20]);
      if (imm_i >= 2048) imm_i -= 4096;
      imm_s = int'(w[31:25]) * 32 + int'(w[11:7]);
      if (imm_s >= 2048) imm_s -= 4096;
      imm_b = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      if (imm_b >= 4096) imm_b -= 8192;
      imm_j = int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
              + int'(w[30:21]) * 2;
      if (imm_j >= (1 << 20)) imm_j -= (1 << 21);

      e = '{default: 0};
      e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
      legal = 1'b1;
      case (op)
         OPC_LUI:   begin e.imm = w & 32'hFFFFF000; e.op2 = OP2_IMM; e.alu = ALU_COPY_B; e.we = 1; end
         OPC_AUIPC: begin e.imm = w & 32'hFFFFF000; e.op1 = OP1_PC; e.op2 = OP2_IMM;
                          e.alu = ALU_ADD; e.we = 1; end
         OPC_JAL:   begin e.imm = 32'(imm_j); e.pc_sel = PC_JAL; e.op1 = OP1_PC; e.op2 = OP2_IMM;
                          e.alu = ALU_ADD; e.wb = WB_PC4; e.we = 1; end
         OPC_JALR:  begin legal = (f3 == 0); e.imm = 32'(imm_i); e.pc_sel = PC_JALR;
                          e.op2 = OP2_IMM; e.alu = ALU_ADD; e.wb = WB_PC4; e.we = 1; end
         OPC_BR:    begin legal = (br_tab[f3] >= 0); e.br = br_tab[f3]; e.imm = 32'(imm_b);
                          e.pc_sel = PC_BR; e.op1 = OP1_PC; e.op2 = OP2_IMM; e.alu = ALU_ADD; end
         OPC_LOAD:  begin legal = !(f3 inside {3, 6, 7}); e.imm = 32'(imm_i); e.op2 = OP2_IMM;
                          e.alu = ALU_ADD; e.wb = WB_MEM; e.we = 1; e.re = 1; e.size = f3; end
         OPC_STORE: begin legal = (f3 < 3); e.imm = 32'(imm_s); e.op2 = OP2_IMM;
                          e.alu = ALU_ADD; e.wr = 1; e.size = f3; end
         OPC_OPIMM: begin
            e.imm = 32'(imm_i); e.op2 = OP2_IMM; e.we = 1; e.alu = alu_tab[f3];
            if (f3 == 1) legal = (f7 == 0);
            if (f3 == 5) begin
               legal = (f7 == 0) || (f7 == 32);
               if (f7 == 32) e.alu = ALU_SRA;
            end
         end
         OPC_OP: begin
            e.we = 1;
            if (f7 == 0)                          e.alu = alu_tab[f3];
            else if (f7 == 32 && f3 == 0)         e.alu = ALU_SUB;
            else if (f7 == 32 && f3 == 5)         e.alu = ALU_SRA;
            else if (f7 == 1 && m)                e.alu = int'(ALU_MUL) + f3;
            else                                  legal = 1'b0;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         n = '{default: 0};
         n.rs1 = e.rs1; n.rs2 = e.rs2; n.rd = e.rd; n.ill = 1;
         e = n;
      end
      if (e.rd == 0) e.we = 0;
      return e;
   endfunction

   // Advance the model across one rising edge, using the pre-edge inputs.
   task automatic model_update();
      bit v = (q.size() > 0);
      bit r = (q.size() < 2);
      if (v && dec_ready_in) begin
         void'(q.pop_front());
         exp_count++;
      end
      if (flush_in) q.delete();
      else if (inst_valid_in && r) q.push_back('{inst: inst_in, pc: pc_in});
   endtask

   // Compare process: every cycle, both instances against the model.
   task automatic check_outputs();
      exp_t e;
      bit   have = (q.size() > 0);
      for (int d = 0; d < 2; d++) begin
         string p = $sformatf("dut%0d", d);
         check({p, ".dec_valid"},  dec_valid[d],  have);
         check({p, ".inst_ready"}, inst_ready[d], q.size() < 2);
         check({p, ".count"},      count[d],      exp_count);
         if (have) begin
            e = ref_decode(q[0].inst, d == 1);
            check({p, ".pc"},   pc[d],   q[0].pc);
            check({p, ".rs1"},  rs1[d],  e.rs1);
            check({p, ".rs2"},  rs2[d],  e.rs2);
            check({p, ".rd"},   rd[d],   e.rd);
            check({p, ".imm"},  imm[d],  e.imm);
            check({p, ".br"},   br[d],   e.br);
            check({p, ".pcsel"}, pcs[d], e.pc_sel);
            check({p, ".op1"},  op1[d],  e.op1);
            check({p, ".op2"},  op2[d],  e.op2);
            check({p, ".wb"},   wb[d],   e.wb);
            check({p, ".alu"},  alu[d],  e.alu);
            check({p, ".we"},   we[d],   e.we);
            check({p, ".re"},   re[d],   e.re);
            check({p, ".wr"},   wr[d],   e.wr);
            check({p, ".size"}, size[d], e.size);
            check({p, ".ill"},  ill[d],  e.ill);
         end
      end
   endtask

   task automatic reset_literals(input string tag);
      for (int d = 0; d < 2; d++) begin
         string p = $sformatf("%s.dut%0d", tag, d);
         check({p, ".valid"}, dec_valid[d], 0);
         check({p, ".ready"}, inst_ready[d], 1);
         check({p, ".count"}, count[d], 0);
         check({p, ".ill"},   ill[d], 0);
         check({p, ".imm"},   imm[d], 0);
         check({p, ".alu"},   alu[d], ALU_NONE);
         check({p, ".br"},    br[d], BR_NONE);
         check({p, ".pcsel"}, pcs[d], PC_NEXTPC);
         check({p, ".en"},    {we[d], re[d], wr[d]}, 0);
         check({p, ".pc"},    pc[d], 0);
      end
   endtask

   task automatic drive(input bit v, input logic [31:0] i, input logic [31:0] p,
                        input bit dr, input bit fl);
      inst_valid_in = v; inst_in = i; pc_in = p; dec_ready_in = dr; flush_in = fl;
   endtask

   task automatic step();
      @(posedge clk_in);
      if (rst_n_in) model_update();
      @(negedge clk_in);
      check_outputs();
   endtask

   function automatic logic [31:0] gen_inst();
      logic [31:0] w = $urandom;
      logic [6:0]  ops[10] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR,
                               OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, 7'b1111111};
      int          k = $urandom_range(0, 10);
      if (k == 10) return w;
      w[6:0] = ops[k];
      if (ops[k] == OPC_OP || ops[k] == OPC_OPIMM) begin
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
         endcase
      end
      return w;
   endfunction

   function automatic logic [31:0] addi_k(input int k);
      return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
   endfunction

   // ------------------------------------------------------------ stimulus
   logic [4:0] out_log[$];
   int         low_cnt, idx;
   bit         acc;

   initial begin
      rst_n_in  = 1'b1;
      exp_count = 32'd0;
      drive(0, 32'd0, 32'd0, 0, 0);
      #1 rst_n_in = 1'b0;
      #2 reset_literals("reset");
      @(negedge clk_in);
      check_outputs();
      rst_n_in = 1'b1;

      // addi x1,x0,5 at pc 0x100
      drive(1, 32'h00500093, 32'h100, 1, 0);
      step();
      drive(0, 32'd0, 32'd0, 1, 0);
      check("addi.valid", dec_valid[0], 1);
      check("addi.rd",    rd[0], 1);
      check("addi.rs1",   rs1[0], 0);
      check("addi.imm",   imm[0], 5);
      check("addi.alu",   alu[0], ALU_ADD);
      check("addi.we",    we[0], 1);
      check("addi.ill",   ill[0], 0);
      check("addi.pc",    pc[0], 32'h100);
      step();

      // Four ADDIs, one-cycle downstream stall while the 2nd is presented
      idx = 0; low_cnt = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         drive(idx < 4, addi_k(idx + 1), 32'h200 + 32'(4 * idx), cyc != 2, 0);
         if (dec_valid[0] && dec_ready_in) out_log.push_back(rd[0]);
         if (!inst_ready[0]) low_cnt++;
         acc = (idx < 4) && (q.size() < 2);
         step();
         if (acc) idx++;
      end
      check("stream.n_out", out_log.size(), 4);
      for (int i = 0; i < out_log.size(); i++)
         check($sformatf("stream.order%0d", i), out_log[i], i + 1);
      check("stream.ready_low", low_cnt, 1);
      check("stream.count", count[0], 5);

      // mul x3,x1,x2
      drive(1, 32'h022081B3, 32'h300, 1, 0);
      step();
      drive(0, 32'd0, 32'd0, 1, 0);
      check("mul.m0.ill", ill[0], 1);
      check("mul.m0.we",  we[0], 0);
      check("mul.m1.ill", ill[1], 0);
      check("mul.m1.alu", alu[1], ALU_MUL);
      check("mul.m1.we",  we[1], 1);
      step();

      // add x0,x1,x2
      drive(1, 32'h00208033, 32'h304, 1, 0);
      step();
      drive(0, 32'd0, 32'd0, 1, 0);
      check("addx0.we",  we[0], 0);
      check("addx0.ill", ill[0], 0);
      step();

      // LOAD funct3 010 (legal) vs 011 (illegal)
      drive(1, 32'h0000A003, 32'h308, 1, 0);
      step();
      drive(1, 32'h0000B003, 32'h30C, 1, 0);
      check("lw.ill", ill[0], 0);
      step();
      drive(0, 32'd0, 32'd0, 1, 0);
      check("ld011.ill", ill[0], 1);
      step();

      // Fill OR and SK, then flush
      drive(1, addi_k(7), 32'h400, 0, 0);
      step();
      drive(1, addi_k(8), 32'h404, 0, 0);
      step();
      check("full.ready", inst_ready[0], 0);
      check("full.valid", dec_valid[0], 1);
      drive(1, addi_k(9), 32'h408, 0, 1);
      step();
      drive(0, 32'd0, 32'd0, 1, 0);
      check("flush.valid", dec_valid[0], 0);
      check("flush.ready", inst_ready[0], 1);
      check("flush.count", count[0], 9);
      step();

      // Randomised traffic with an asynchronous reset mid-stream
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0, gen_inst(), {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
               $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
         if (i == 1500) begin
            @(posedge clk_in);
            model_update();
            #2 rst_n_in = 1'b0;
            #1 reset_literals("async_rst");
            q.delete();
            exp_count = 32'd0;
            @(negedge clk_in);
            check_outputs();
            step();
            rst_n_in = 1'b1;
         end else begin
            step();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
